// File: rtl/alu_pipe.sv
// alu_pipe: pipelined ALU with valid/ready handshake, one output register stage.
// Computes binary or nibble-decimal arithmetic, logic ops, shifts/rotates and
// compare, and returns result, N/Z/C/V flags and a flag-write mask.
module alu_pipe #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          DECIMAL_EN = 1'b1,
    parameter int unsigned TAG_W      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       in_mode,
    input  logic             in_carry,
    input  logic             in_dec,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_n,
    output logic             out_z,
    output logic             out_c,
    output logic             out_v,
    output logic [3:0]       out_fmask,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned DIGITS = WIDTH / 4;

    localparam logic [3:0] MODE_ADC   = 4'd0;
    localparam logic [3:0] MODE_SBC   = 4'd1;
    localparam logic [3:0] MODE_AND   = 4'd2;
    localparam logic [3:0] MODE_OR    = 4'd3;
    localparam logic [3:0] MODE_EOR   = 4'd4;
    localparam logic [3:0] MODE_ASL   = 4'd5;
    localparam logic [3:0] MODE_LSR   = 4'd6;
    localparam logic [3:0] MODE_ROL   = 4'd7;
    localparam logic [3:0] MODE_ROR   = 4'd8;
    localparam logic [3:0] MODE_CMP   = 4'd9;
    localparam logic [3:0] MODE_INC   = 4'd10;
    localparam logic [3:0] MODE_DEC   = 4'd11;
    localparam logic [3:0] MODE_PASSB = 4'd12;

    logic             accept;
    logic             is_sub;
    logic             cin_eff;
    logic             dec_on;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   bin_sum;
    logic [WIDTH-1:0] dec_res;
    logic [4:0]       digit;
    logic             digit_c;
    logic             v_raw;
    logic [WIDTH-1:0] res;
    logic             c_flag;
    logic             v_flag;
    logic [3:0]       fmask;
    logic [3:0]       flags;

    // The output register can take a new op whenever it is empty or draining.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Combinational datapath: binary sum, decimal digit chain, mode select, flags.
    always_comb begin
        is_sub  = (in_mode == MODE_SBC) || (in_mode == MODE_CMP);
        b_eff   = is_sub ? ~in_b : in_b;
        cin_eff = (in_mode == MODE_CMP) ? 1'b1 : in_carry;
        bin_sum = {1'b0, in_a} + {1'b0, b_eff} + (WIDTH+1)'(cin_eff);
        v_raw   = (in_a[WIDTH-1] == b_eff[WIDTH-1]) && (bin_sum[WIDTH-1] != in_a[WIDTH-1]);
        dec_on  = DECIMAL_EN && in_dec && ((in_mode == MODE_ADC) || (in_mode == MODE_SBC));

        // Digit chain: low 4 bits of the 5-bit digit survive the +/-6 wraparound.
        dec_res = '0;
        digit   = '0;
        digit_c = in_carry;
        for (int i = 0; i < int'(DIGITS); i++) begin
            digit = 5'(in_a[i*4 +: 4]) + 5'(b_eff[i*4 +: 4]) + 5'(digit_c);
            if (in_mode == MODE_SBC) begin
                if (!digit[4]) begin
                    digit   = digit - 5'd6;
                    digit_c = 1'b0;
                end else begin
                    digit_c = 1'b1;
                end
            end else begin
                if (digit > 5'd9) begin
                    digit   = digit + 5'd6;
                    digit_c = 1'b1;
                end else begin
                    digit_c = 1'b0;
                end
            end
            dec_res[i*4 +: 4] = digit[3:0];
        end

        res    = in_a;
        c_flag = 1'b0;
        v_flag = 1'b0;
        fmask  = 4'b1100;
        case (in_mode)
            MODE_ADC, MODE_SBC: begin
                fmask  = 4'b1111;
                v_flag = v_raw;
                if (dec_on) begin
                    res    = dec_res;
                    c_flag = digit_c;
                end else begin
                    res    = bin_sum[WIDTH-1:0];
                    c_flag = bin_sum[WIDTH];
                end
            end
            MODE_AND:   res = in_a & in_b;
            MODE_OR:    res = in_a | in_b;
            MODE_EOR:   res = in_a ^ in_b;
            MODE_ASL: begin
                res    = {in_a[WIDTH-2:0], 1'b0};
                c_flag = in_a[WIDTH-1];
                fmask  = 4'b1110;
            end
            MODE_LSR: begin
                res    = {1'b0, in_a[WIDTH-1:1]};
                c_flag = in_a[0];
                fmask  = 4'b1110;
            end
            MODE_ROL: begin
                res    = {in_a[WIDTH-2:0], in_carry};
                c_flag = in_a[WIDTH-1];
                fmask  = 4'b1110;
            end
            MODE_ROR: begin
                res    = {in_carry, in_a[WIDTH-1:1]};
                c_flag = in_a[0];
                fmask  = 4'b1110;
            end
            MODE_CMP: begin
                res    = bin_sum[WIDTH-1:0];
                c_flag = bin_sum[WIDTH];
                fmask  = 4'b1110;
            end
            MODE_INC:   res = in_a + WIDTH'(1);
            MODE_DEC:   res = in_a - WIDTH'(1);
            MODE_PASSB: res = in_b;
            default:    res = in_a;
        endcase

        flags = {res[WIDTH-1], (res == '0), c_flag, v_flag} & fmask;
    end

    // Output register: loads on acceptance, empties when drained with nothing new.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_n      <= 1'b0;
            out_z      <= 1'b0;
            out_c      <= 1'b0;
            out_v      <= 1'b0;
            out_fmask  <= '0;
            out_tag    <= '0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_result <= res;
            out_n      <= flags[3];
            out_z      <= flags[2];
            out_c      <= flags[1];
            out_v      <= flags[0];
            out_fmask  <= fmask;
            out_tag    <= in_tag;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe (8-bit decimal, 8-bit binary-only, 16-bit).
module tb_alu_pipe;

    typedef struct packed {
        logic [15:0] res;
        logic [3:0]  flags;
        logic [3:0]  fmask;
        logic [3:0]  tag;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] mode;
        logic       cin;
        logic       dec;
        logic [7:0] res;
        logic [3:0] flags;
        logic [3:0] fm;
    } vec_t;

    logic clk;
    logic reset;

    logic       in_valid, in_ready, in_carry, in_dec, out_valid, out_ready;
    logic       out_n, out_z, out_c, out_v;
    logic [7:0] in_a, in_b, out_result;
    logic [3:0] in_mode, in_tag, out_fmask, out_tag;

    logic       nd_in_valid, nd_in_ready, nd_in_carry, nd_in_dec, nd_out_valid, nd_out_ready;
    logic       nd_out_n, nd_out_z, nd_out_c, nd_out_v;
    logic [7:0] nd_in_a, nd_in_b, nd_out_result;
    logic [3:0] nd_in_mode, nd_in_tag, nd_out_fmask, nd_out_tag;

    logic        w_in_valid, w_in_ready, w_in_carry, w_in_dec, w_out_valid, w_out_ready;
    logic        w_out_n, w_out_z, w_out_c, w_out_v;
    logic [15:0] w_in_a, w_in_b, w_out_result;
    logic [3:0]  w_in_mode, w_in_tag, w_out_fmask, w_out_tag;

    alu_pipe #(.WIDTH(8), .DECIMAL_EN(1'b1), .TAG_W(4)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_carry(in_carry),
        .in_dec(in_dec), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_n(out_n), .out_z(out_z), .out_c(out_c),
        .out_v(out_v), .out_fmask(out_fmask), .out_tag(out_tag)
    );

    alu_pipe #(.WIDTH(8), .DECIMAL_EN(1'b0), .TAG_W(4)) u_nodec (
        .clk(clk), .reset(reset), .in_valid(nd_in_valid), .in_ready(nd_in_ready),
        .in_a(nd_in_a), .in_b(nd_in_b), .in_mode(nd_in_mode), .in_carry(nd_in_carry),
        .in_dec(nd_in_dec), .in_tag(nd_in_tag), .out_valid(nd_out_valid),
        .out_ready(nd_out_ready), .out_result(nd_out_result), .out_n(nd_out_n),
        .out_z(nd_out_z), .out_c(nd_out_c), .out_v(nd_out_v),
        .out_fmask(nd_out_fmask), .out_tag(nd_out_tag)
    );

    alu_pipe #(.WIDTH(16), .DECIMAL_EN(1'b1), .TAG_W(4)) u_w16 (
        .clk(clk), .reset(reset), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_a(w_in_a), .in_b(w_in_b), .in_mode(w_in_mode), .in_carry(w_in_carry),
        .in_dec(w_in_dec), .in_tag(w_in_tag), .out_valid(w_out_valid),
        .out_ready(w_out_ready), .out_result(w_out_result), .out_n(w_out_n),
        .out_z(w_out_z), .out_c(w_out_c), .out_v(w_out_v),
        .out_fmask(w_out_fmask), .out_tag(w_out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_pass   = 0;
    int    n_out    = 0;
    exp_t  sb[$];
    logic  acc_prev   = 1'b0;
    logic  stall_prev = 1'b0;
    logic [19:0] held = '0;
    vec_t  dir [17];

    // Count one comparison and report it when it does not match.
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
        else n_pass++;
    endtask

    // Reference model written from the operation table, width w (4..16).
    function automatic exp_t model(input int w, input bit dec_en, input logic [15:0] a,
                                   input logic [15:0] b, input logic [3:0] mode,
                                   input logic cin, input logic dec, input logic [3:0] tag);
        int   msk, msb, ai, bi, bp, s, r, c, v, cc, da, db, t;
        logic [3:0] fm;
        logic n, z;
        exp_t e;
        msk = (1 << w) - 1;
        msb = 1 << (w - 1);
        ai  = int'(a) & msk;
        bi  = int'(b) & msk;
        c   = 0;
        v   = 0;
        fm  = 4'b1100;
        r   = ai;
        case (mode)
            4'd0, 4'd1: begin
                fm = 4'b1111;
                bp = (mode == 4'd1) ? (~bi & msk) : bi;
                s  = ai + bp + int'(cin);
                r  = s & msk;
                c  = (s >> w) & 1;
                v  = (((ai ^ bp) & msb) == 0 && ((r ^ ai) & msb) != 0) ? 1 : 0;
                if (dec_en && dec) begin
                    r  = 0;
                    cc = int'(cin);
                    for (int i = 0; i < w / 4; i++) begin
                        da = (ai >> (4 * i)) & 15;
                        db = (bi >> (4 * i)) & 15;
                        if (mode == 4'd0) begin
                            t = da + db + cc;
                            if (t > 9) begin t = t + 6; cc = 1; end else cc = 0;
                        end else begin
                            t = da - db - (1 - cc);
                            if (t < 0) begin t = t - 6; cc = 0; end else cc = 1;
                        end
                        r = r | ((t & 15) << (4 * i));
                    end
                    c = cc;
                end
            end
            4'd2: r = ai & bi;
            4'd3: r = ai | bi;
            4'd4: r = ai ^ bi;
            4'd5: begin r = (ai << 1) & msk; c = (ai >> (w - 1)) & 1; fm = 4'b1110; end
            4'd6: begin r = ai >> 1; c = ai & 1; fm = 4'b1110; end
            4'd7: begin r = ((ai << 1) | int'(cin)) & msk; c = (ai >> (w - 1)) & 1; fm = 4'b1110; end
            4'd8: begin r = (ai >> 1) | (cin ? msb : 0); c = ai & 1; fm = 4'b1110; end
            4'd9: begin
                s  = ai + (~bi & msk) + 1;
                r  = s & msk;
                c  = (s >> w) & 1;
                fm = 4'b1110;
            end
            4'd10: r = (ai + 1) & msk;
            4'd11: r = (ai + msk) & msk;
            4'd12: r = bi;
            default: r = ai;
        endcase
        n = ((r & msb) != 0);
        z = (r == 0);
        e.res   = 16'(r);
        e.flags = {n, z, c[0], v[0]} & fm;
        e.fmask = fm;
        e.tag   = tag;
        return e;
    endfunction

    // One cycle on the main DUT: checks, drive, then handshake bookkeeping.
    task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] mode, input logic cin, input logic dec,
                        input logic [3:0] otag, input logic ordy, input logic use_exp,
                        input exp_t e, output logic accepted);
        exp_t ex;
        @(negedge clk);
        if (acc_prev) check("latency", 64'(out_valid), 64'(1));
        if (stall_prev)
            check("stable", 64'({out_result, out_n, out_z, out_c, out_v, out_fmask, out_tag}),
                  64'(held));
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_mode   = mode;
        in_carry  = cin;
        in_dec    = dec;
        in_tag    = otag;
        out_ready = ordy;
        #1;
        check("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_out", 64'(out_valid), 64'(0));
            end else begin
                ex = sb.pop_front();
                check("result", 64'(out_result), 64'(ex.res[7:0]));
                check("flags", 64'({out_n, out_z, out_c, out_v}), 64'(ex.flags));
                check("fmask", 64'(out_fmask), 64'(ex.fmask));
                check("tag", 64'(out_tag), 64'(ex.tag));
                n_out++;
            end
        end
        accepted = v && in_ready;
        if (accepted) sb.push_back(use_exp ? e : model(8, 1'b1, 16'(a), 16'(b), mode, cin, dec, otag));
        acc_prev   = accepted;
        stall_prev = out_valid && !out_ready;
        held       = {out_result, out_n, out_z, out_c, out_v, out_fmask, out_tag};
    endtask

    // Idle-cycle drain of the scoreboard with the consumer always ready.
    task automatic drain(input string name);
        logic acc;
        for (int k = 0; k < 20 && (sb.size() != 0 || out_valid); k++)
            step(1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, '0, acc);
        check(name, 64'(sb.size()), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        logic [3:0] tagc;
        exp_t e;
        int   out_before;

        dir[0]  = '{8'h50, 8'h50, 4'd0,  1'b0, 1'b0, 8'hA0, 4'b1001, 4'b1111};
        dir[1]  = '{8'h00, 8'h01, 4'd1,  1'b1, 1'b0, 8'hFF, 4'b1000, 4'b1111};
        dir[2]  = '{8'h40, 8'h40, 4'd9,  1'b0, 1'b0, 8'h00, 4'b0110, 4'b1110};
        dir[3]  = '{8'h58, 8'h46, 4'd0,  1'b1, 1'b1, 8'h05, 4'b0011, 4'b1111};
        dir[4]  = '{8'h12, 8'h21, 4'd1,  1'b1, 1'b1, 8'h91, 4'b1000, 4'b1111};
        dir[5]  = '{8'h01, 8'h00, 4'd8,  1'b1, 1'b0, 8'h80, 4'b1010, 4'b1110};
        dir[6]  = '{8'h80, 8'h00, 4'd5,  1'b0, 1'b0, 8'h00, 4'b0110, 4'b1110};
        dir[7]  = '{8'hF0, 8'h3C, 4'd2,  1'b0, 1'b0, 8'h30, 4'b0000, 4'b1100};
        dir[8]  = '{8'h0F, 8'hF0, 4'd3,  1'b0, 1'b0, 8'hFF, 4'b1000, 4'b1100};
        dir[9]  = '{8'hFF, 8'hFF, 4'd4,  1'b0, 1'b0, 8'h00, 4'b0100, 4'b1100};
        dir[10] = '{8'h03, 8'h00, 4'd6,  1'b0, 1'b0, 8'h01, 4'b0010, 4'b1110};
        dir[11] = '{8'h80, 8'h00, 4'd7,  1'b1, 1'b0, 8'h01, 4'b0010, 4'b1110};
        dir[12] = '{8'hFF, 8'h00, 4'd10, 1'b0, 1'b0, 8'h00, 4'b0100, 4'b1100};
        dir[13] = '{8'h00, 8'h00, 4'd11, 1'b0, 1'b0, 8'hFF, 4'b1000, 4'b1100};
        dir[14] = '{8'h12, 8'h7E, 4'd12, 1'b0, 1'b0, 8'h7E, 4'b0000, 4'b1100};
        dir[15] = '{8'h81, 8'h00, 4'd13, 1'b0, 1'b0, 8'h81, 4'b1000, 4'b1100};
        dir[16] = '{8'h10, 8'h20, 4'd9,  1'b1, 1'b0, 8'hF0, 4'b1000, 4'b1110};

        reset = 1'b1;
        in_valid = 0; in_a = 0; in_b = 0; in_mode = 0; in_carry = 0; in_dec = 0; in_tag = 0;
        out_ready = 1'b1;
        nd_in_valid = 0; nd_in_a = 0; nd_in_b = 0; nd_in_mode = 0; nd_in_carry = 0;
        nd_in_dec = 0; nd_in_tag = 0; nd_out_ready = 1'b1;
        w_in_valid = 0; w_in_a = 0; w_in_b = 0; w_in_mode = 0; w_in_carry = 0;
        w_in_dec = 0; w_in_tag = 0; w_out_ready = 1'b1;

        #1;
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_outs", 64'({out_result, out_n, out_z, out_c, out_v, out_fmask, out_tag}), 64'(0));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'(1));

        // Directed vectors with constant expectations, back-to-back.
        for (int i = 0; i < 17; i++) begin
            e.res   = 16'(dir[i].res);
            e.flags = dir[i].flags;
            e.fmask = dir[i].fm;
            e.tag   = 4'(i);
            step(1'b1, dir[i].a, dir[i].b, dir[i].mode, dir[i].cin, dir[i].dec, 4'(i),
                 1'b1, 1'b1, e, acc);
        end
        drain("drain_directed");

        // Tags 1..6 held until accepted while the consumer toggles randomly.
        out_before = n_out;
        for (int t = 1; t <= 6; t++) begin
            acc = 1'b0;
            for (int k = 0; k < 50 && !acc; k++)
                step(1'b1, 8'(t * 17), 8'(t * 5), 4'(t), 1'(t & 1), 1'b0, 4'(t),
                     1'($urandom_range(0, 1)), 1'b0, '0, acc);
            check("bp_accept", 64'(acc), 64'(1));
        end
        drain("drain_bp");
        check("bp_count", 64'(n_out - out_before), 64'(6));

        // Random ops, random valid and random backpressure.
        tagc = 4'd0;
        for (int k = 0; k < 80; k++) begin
            step(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 tagc, 1'($urandom_range(0, 1)), 1'b0, '0, acc);
            if (acc) tagc = tagc + 4'd1;
        end
        drain("drain_random");

        // Binary-only instance ignores in_dec.
        @(negedge clk);
        check("nd_in_ready", 64'(nd_in_ready), 64'(1));
        nd_in_valid = 1'b1; nd_in_a = 8'h58; nd_in_b = 8'h46; nd_in_mode = 4'd0;
        nd_in_carry = 1'b1; nd_in_dec = 1'b1; nd_in_tag = 4'd9;
        @(negedge clk);
        nd_in_valid = 1'b0;
        check("nd_valid", 64'(nd_out_valid), 64'(1));
        check("nd_result", 64'(nd_out_result), 64'(8'h9F));
        check("nd_flags", 64'({nd_out_n, nd_out_z, nd_out_c, nd_out_v}), 64'(4'b1001));
        check("nd_fmask_tag", 64'({nd_out_fmask, nd_out_tag}), 64'({4'b1111, 4'd9}));

        // 16-bit carry/zero, then hold results in both 8- and 16-bit units.
        w_in_valid = 1'b1; w_in_a = 16'hFFFF; w_in_b = 16'h0001; w_in_mode = 4'd0;
        w_in_carry = 1'b0; w_in_dec = 1'b0; w_in_tag = 4'd5; w_out_ready = 1'b0;
        in_valid = 1'b1; in_a = 8'h01; in_b = 8'h01; in_mode = 4'd0; in_carry = 1'b0;
        in_dec = 1'b0; in_tag = 4'd3; out_ready = 1'b0;
        @(negedge clk);
        w_in_valid = 1'b0;
        in_valid   = 1'b0;
        check("w_valid", 64'(w_out_valid), 64'(1));
        check("w_result", 64'(w_out_result), 64'(16'h0000));
        check("w_flags", 64'({w_out_n, w_out_z, w_out_c, w_out_v}), 64'(4'b0110));
        check("w_stall_ready", 64'(w_in_ready), 64'(0));
        check("held_valid", 64'(out_valid), 64'(1));
        check("held_result", 64'(out_result), 64'(8'h02));

        // Asynchronous reset mid-cycle drops held results without a handshake.
        #3;
        reset = 1'b1;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'(0));
        check("mid_rst_outs", 64'({out_result, out_n, out_z, out_c, out_v, out_fmask, out_tag}), 64'(0));
        check("w_rst_valid", 64'(w_out_valid), 64'(0));
        check("w_rst_outs", 64'({w_out_result, w_out_n, w_out_z, w_out_c, w_out_v, w_out_fmask, w_out_tag}), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_rst_ready", 64'(in_ready), 64'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, pipelined arithmetic/logic unit for the CPU datapath: the successor to the single-register 8-bit ALU. It accepts one operation per cycle through a valid/ready handshake and returns the result, the N/Z/C/V flags and a flag-update mask one cycle later. It adds subtraction, shifts and rotates, compare, increment/decrement and optional nibble-wise decimal add/subtract, and it supports downstream backpressure.

## Interface
- WIDTH, 8, operand/result width; must be a multiple of 4 and at least 4
- DECIMAL_EN, 1, 1 = BCD add/subtract supported; 0 = `in_dec` ignored
- TAG_W, 4, width of the opaque tag carried alongside each operation
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  operation presented
- in_ready  out  1  operation accepted this cycle when in_valid && in_ready
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_mode  in  4  operation select (see Operation)
- in_carry  in  1  carry input
- in_dec  in  1  decimal mode for ADC/SBC
- in_tag  in  TAG_W  passed through unchanged
- out_valid  out  1  result held
- out_ready  in  1  consumer accepts result
- out_result  out  WIDTH  result
- out_n, out_z, out_c, out_v  out  1 each  flags
- out_fmask  out  4  {N,Z,C,V}: 1 = flag is written by this op
- out_tag  out  TAG_W  tag of this result

## Operation
- Modes: 0 ADC A+B+cin; 1 SBC A+~B+cin; 2 AND; 3 OR; 4 EOR; 5 ASL (A<<1, C=A[W-1]); 6 LSR (A>>1, C=A[0]); 7 ROL (A<<1 with bit0=cin, C=A[W-1]); 8 ROR (A>>1 with msb=cin, C=A[0]); 9 CMP (A+~B+1, cin ignored); 10 INC A+1; 11 DEC A-1; 12 PASSB; 13-15 PASSA.
- Arithmetic is computed at WIDTH+1 bits; C = bit WIDTH. For SBC/CMP, C=1 means no borrow.
- V (ADC/SBC only) = (A[msb]==B'[msb]) && (R[msb]!=A[msb]), where B' = B for ADC and ~B for SBC. V is 0 for all other modes.
- N = result[WIDTH-1]. Z = (result==0).
- out_fmask: ADC/SBC 1111; CMP and shifts/rotates 1110; AND/OR/EOR/INC/DEC/PASSA/PASSB 1100. Flag outputs whose mask bit is 0 are driven 0.
- Decimal mode applies when DECIMAL_EN && in_dec && mode in {ADC, SBC}. The result is computed per nibble from LSB to MSB with a digit carry between nibbles.
  - ADC: if digit sum > 9, add 6 and carry.
  - SBC: if digit borrows, subtract 6.
  - C = final digit carry/no-borrow.
  - V = binary-mode V for the same operands.
  - N and Z are taken from the decimal result.
  - Non-BCD input digits are processed by the same rule, with no error.
- Datapath is combinational into a single output register stage: result, flags, mask and tag are all registered.

## Timing
- Reset: out_valid=0, out_result=0, all flags 0, out_fmask=0, out_tag=0. in_ready=1 as soon as reset deasserts.
- in_ready = !out_valid || out_ready. This is combinational from out_ready; there is no path from in_valid to in_ready.
- Latency is 1 cycle: an op accepted at edge k appears with out_valid=1 after edge k.
- Throughput is 1 op/cycle while out_ready=1.
- A result is transferred when out_valid && out_ready.
  - If a new op is accepted in the same cycle, the output register loads it and out_valid stays 1.
  - If no new op is accepted, out_valid goes to 0.
- Stall: while out_valid && !out_ready, all out_* are held stable and in_ready=0. Inputs are not sampled.
- The output register updates only on acceptance. Operands changing while in_valid=0 or in_ready=0 have no effect.
- Reset asserted mid-stream drops any held result immediately (asynchronous); no partial result is emitted.

## Test plan
- WIDTH=8, ADC 0x50+0x50, cin=0 -> result 0xA0, N=1, Z=0, C=0, V=1, fmask 1111, one cycle after accept.
- SBC 0x00-0x01, cin=1 -> result 0xFF, C=0, N=1, V=0. CMP 0x40 vs 0x40 -> result 0x00, Z=1, C=1, fmask 1110.
- Decimal: ADC 0x58+0x46, cin=1, in_dec=1 -> 0x05, C=1. SBC 0x12-0x21, cin=1 -> 0x91, C=0. With DECIMAL_EN=0 the same ADC gives 0x9F.
- Shifts/rotates: ROR 0x01, cin=1 -> 0x80, C=1, N=1. ASL 0x80 -> 0x00, Z=1, C=1.
- Backpressure: stream tags 1..6 with out_ready toggling randomly -> all six results emerge in order, each exactly once, with outputs stable during stalls and in_ready low whenever out_valid && !out_ready.
- WIDTH=16: ADC 0xFFFF+0x0001 -> 0x0000, C=1, Z=1. Assert reset while out_valid=1 -> out_valid=0 with no handshake needed, and all outputs return to reset values.
